// File: rtl/cache_fill_ctrl.sv
// Miss sequencer for one cache line: optional dirty-victim write-back, word-by-word
// refill into the line adapter, commit strobe, then adapter clear.
module cache_fill_ctrl #(
  parameter int WORDS   = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     miss_req,
  input  logic [ADDR_W-1:0]        miss_addr,
  input  logic                     dirty,
  input  logic [ADDR_W-1:0]        victim_addr,
  output logic [$clog2(WORDS)-1:0] vic_idx,
  input  logic [DATA_W-1:0]        vic_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     cla_we,
  output logic                     cla_next,
  output logic [ADDR_W-1:0]        cla_addr,
  output logic [DATA_W-1:0]        cla_data,
  input  logic                     cla_full,
  output logic                     cla_clr,
  output logic                     line_we,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  // state       | meaning
  // S_IDLE      | waiting for miss_req
  // S_WB        | writing victim word cnt to memory
  // S_FILL      | reading new-line word cnt from memory into the adapter
  // S_WAIT_FULL | waiting for the adapter to report a full line
  // S_COMMIT    | one-cycle line_we to the cache array
  // S_DONE      | one-cycle done + adapter clear
  // S_ERR       | one-cycle err + adapter clear after a timeout

  localparam int IDX_W = $clog2(WORDS);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(WORDS * 4 - 1));

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_FILL, S_WAIT_FULL, S_COMMIT, S_DONE, S_ERR
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   cnt;
  logic [TMO_W-1:0]   tmo;
  logic [ADDR_W-1:0]  miss_base, victim_base;
  logic [ADDR_W-1:0]  word_ofs;
  logic               last_word, tmo_hit, xfer;

  assign last_word = (cnt == IDX_W'(WORDS - 1));
  assign tmo_hit   = (tmo == TMO_W'(TIMEOUT - 1));
  assign xfer      = mem_req & mem_ack;
  assign word_ofs  = ADDR_W'({cnt, 2'b00});

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (miss_req) state_nxt = dirty ? S_WB : S_FILL;
      S_WB:        if (mem_ack) begin
                     if (last_word) state_nxt = S_FILL;
                   end else if (tmo_hit) state_nxt = S_ERR;
      S_FILL:      if (mem_ack) begin
                     if (last_word) state_nxt = S_WAIT_FULL;
                   end else if (tmo_hit) state_nxt = S_ERR;
      S_WAIT_FULL: if (cla_full) state_nxt = S_COMMIT;
                   else if (tmo_hit) state_nxt = S_ERR;
      S_COMMIT:    state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      S_ERR:       state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Flag outputs are registered from the next state so they line up with it exactly.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tmo         <= '0;
      miss_base   <= '0;
      victim_base <= '0;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      line_we     <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cla_clr     <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != S_IDLE);
      mem_req <= (state_nxt == S_WB) || (state_nxt == S_FILL);
      mem_we  <= (state_nxt == S_WB);
      line_we <= (state_nxt == S_COMMIT);
      done    <= (state_nxt == S_DONE);
      err     <= (state_nxt == S_ERR);
      cla_clr <= (state_nxt == S_DONE) || (state_nxt == S_ERR);

      if (state == S_IDLE && miss_req) begin
        miss_base   <= miss_addr & LINE_MASK;
        victim_base <= victim_addr & LINE_MASK;
        cnt         <= '0;
      end else if (xfer) begin
        cnt <= cnt + IDX_W'(1);  // wraps to 0 after the last word
      end

      if (state_nxt != state || xfer)
        tmo <= '0;
      else if (state == S_WB || state == S_FILL || state == S_WAIT_FULL)
        tmo <= tmo + TMO_W'(1);
    end
  end

  always_comb begin
    vic_idx   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    cla_we    = 1'b0;
    cla_next  = 1'b0;
    cla_addr  = '0;
    cla_data  = '0;
    if (state == S_WB) begin
      vic_idx   = cnt;
      mem_addr  = victim_base + word_ofs;
      mem_wdata = vic_rdata;
    end else if (state == S_FILL) begin
      mem_addr = miss_base + word_ofs;
      if (mem_ack) begin
        cla_we   = 1'b1;
        cla_next = 1'b1;
        cla_addr = ADDR_W'(cnt);
        cla_data = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a req/ack memory model and a counting line adapter.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        dirty;
  logic [31:0] victim_addr;
  logic [2:0]  vic_idx;
  logic [31:0] vic_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        cla_we, cla_next;
  logic [31:0] cla_addr, cla_data;
  logic        cla_full, cla_clr;
  logic        line_we, busy, done, err;

  cache_fill_ctrl #(.WORDS(8), .ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
    .clk(clk), .clr(clr), .miss_req(miss_req), .miss_addr(miss_addr), .dirty(dirty),
    .victim_addr(victim_addr), .vic_idx(vic_idx), .vic_rdata(vic_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .cla_we(cla_we), .cla_next(cla_next),
    .cla_addr(cla_addr), .cla_data(cla_data), .cla_full(cla_full), .cla_clr(cla_clr),
    .line_we(line_we), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  assign vic_rdata = 32'hA5A5_0000 + 32'(vic_idx);

  // line adapter model: counts advance strobes, full at 8 words
  int ad_cnt;
  always @(posedge clk or negedge clr)
    if (!clr)         ad_cnt <= 0;
    else if (cla_clr) ad_cnt <= 0;
    else if (cla_next) ad_cnt <= ad_cnt + 1;
  assign cla_full = (ad_cnt >= 8);

  // memory model: ack after ack_gap idle request cycles, at most ack_budget acks (<0 = unlimited)
  int ack_gap = 0;
  int ack_budget = -1;
  int wait_cnt = 0;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req && ack_budget != 0) begin
      if (wait_cnt >= ack_gap) begin
        mem_ack = 1'b1;
        wait_cnt = 0;
        if (ack_budget > 0) ack_budget--;
      end else begin
        wait_cnt++;
      end
    end
    mem_rdata = mem_ack ? (32'hFFFF_FFFF - ((mem_addr >> 2) & 32'd7)) : 32'h0;
  end

  // event log
  int n_rd, n_wr, n_nx, n_line, n_done, n_err, n_unstable, n_bad_we;
  int line_cyc, done_cyc, err_cyc, clr_cyc;
  logic [31:0] rd_addr [16];
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  logic [2:0]  wr_idx  [16];
  logic [31:0] nx_addr [16];
  logic [31:0] nx_data [16];
  logic        prev_wait, prev_we;
  logic [31:0] prev_addr, prev_wdata;

  task automatic clear_log();
    n_rd = 0; n_wr = 0; n_nx = 0; n_line = 0; n_done = 0; n_err = 0;
    n_unstable = 0; n_bad_we = 0;
    line_cyc = -1; done_cyc = -1; err_cyc = -1; clr_cyc = -1;
    prev_wait = 1'b0;
  endtask

  always @(negedge clk) begin
    #1;
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        if (n_wr < 16) begin
          wr_addr[n_wr] = mem_addr; wr_idx[n_wr] = vic_idx; wr_data[n_wr] = mem_wdata;
        end
        n_wr++;
      end else begin
        if (n_rd < 16) rd_addr[n_rd] = mem_addr;
        n_rd++;
      end
    end
    if (cla_next) begin
      if (n_nx < 16) begin nx_addr[n_nx] = cla_addr; nx_data[n_nx] = cla_data; end
      n_nx++;
    end
    if (cla_next != cla_we) n_bad_we++;
    if (prev_wait && mem_req &&
        (mem_addr != prev_addr || mem_we != prev_we || mem_wdata != prev_wdata))
      n_unstable++;
    prev_wait = mem_req && !mem_ack;
    prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
    if (line_we) begin n_line++; line_cyc = cyc - start; end
    if (done)    begin n_done++; done_cyc = cyc - start; end
    if (err)     begin n_err++;  err_cyc  = cyc - start; end
    if (cla_clr) clr_cyc = cyc - start;
  end

  task automatic wait_end();
    for (int k = 0; k < 300 && n_done == 0 && n_err == 0; k++) @(negedge clk);
    chk("finish_bound", 64'((n_done + n_err) != 0), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_miss(input logic [31:0] a, input logic d, input logic [31:0] v);
    @(negedge clk);
    miss_addr = a; dirty = d; victim_addr = v; miss_req = 1'b1;
    start = cyc; wait_cnt = 0; clear_log();
    @(negedge clk);
    miss_req = 1'b0;
    wait_end();
  endtask

  task automatic check_fill(input string tag, input logic [31:0] base);
    chk({tag, "_n_rd"}, 64'(n_rd), 64'd8);
    chk({tag, "_n_next"}, 64'(n_nx), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_rd_addr"}, 64'(rd_addr[i]), 64'(base + 32'(4 * i)));
      chk({tag, "_cla_addr"}, 64'(nx_addr[i]), 64'(i));
      chk({tag, "_cla_data"}, 64'(nx_data[i]), 64'(32'hFFFF_FFFF - 32'(i)));
    end
    chk({tag, "_we_next"}, 64'(n_bad_we), 64'd0);
  endtask

  initial begin
    clr = 1'b0; miss_req = 1'b0; miss_addr = '0; dirty = 1'b0; victim_addr = '0;
    clear_log();
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req", 64'({mem_req, mem_we, line_we, done, err, cla_clr, cla_we, cla_next}), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_vic_idx", 64'(vic_idx), 64'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);

    // clean miss, ack every cycle
    run_miss(32'h0000_1234, 1'b0, 32'h0);
    check_fill("clean", 32'h0000_1220);
    chk("clean_n_wr", 64'(n_wr), 64'd0);
    chk("clean_line_cyc", 64'(line_cyc), 64'd10);
    chk("clean_done_cyc", 64'(done_cyc), 64'd11);
    chk("clean_clr_cyc", 64'(clr_cyc), 64'd11);
    chk("clean_counts", 64'({8'(n_line), 8'(n_done), 8'(n_err)}), 64'h01_01_00);
    chk("clean_busy_after", 64'(busy), 64'd0);

    // dirty miss: write-back then fill
    run_miss(32'h0000_1234, 1'b1, 32'h8000_0044);
    chk("dirty_n_wr", 64'(n_wr), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("dirty_wr_addr", 64'(wr_addr[i]), 64'(32'h8000_0040 + 32'(4 * i)));
      chk("dirty_vic_idx", 64'(wr_idx[i]), 64'(i));
      chk("dirty_wdata", 64'(wr_data[i]), 64'(32'hA5A5_0000 + 32'(i)));
    end
    check_fill("dirty", 32'h0000_1220);
    chk("dirty_line_cyc", 64'(line_cyc), 64'd18);
    chk("dirty_done_cyc", 64'(done_cyc), 64'd19);

    // wait states: ack every third request cycle
    ack_gap = 2;
    run_miss(32'h0000_3010, 1'b0, 32'h0);
    ack_gap = 0;
    check_fill("wait", 32'h0000_3000);
    chk("wait_unstable", 64'(n_unstable), 64'd0);
    chk("wait_counts", 64'({8'(n_line), 8'(n_done), 8'(n_err)}), 64'h01_01_00);
    chk("wait_line_before_done", 64'(line_cyc + 1 == done_cyc), 64'd1);

    // timeout while waiting for word 3
    ack_budget = 3;
    run_miss(32'h0000_1234, 1'b0, 32'h0);
    ack_budget = -1;
    chk("tmo_n_next", 64'(n_nx), 64'd3);
    chk("tmo_err_cyc", 64'(err_cyc), 64'd68);
    chk("tmo_clr_cyc", 64'(clr_cyc), 64'd68);
    chk("tmo_counts", 64'({8'(n_line), 8'(n_done), 8'(n_err)}), 64'h00_00_01);
    chk("tmo_busy_after", 64'(busy), 64'd0);

    // async reset during fill word 5
    @(negedge clk);
    miss_addr = 32'h0000_1234; dirty = 1'b0; miss_req = 1'b1;
    start = cyc; wait_cnt = 0; clear_log();
    @(negedge clk);
    miss_req = 1'b0;
    while (cyc - start < 6) @(negedge clk);
    chk("mid_pre_busy", 64'(busy), 64'd1);
    #2 clr = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_flags", 64'({mem_req, mem_we, line_we, done, err, cla_clr, cla_we, cla_next}), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    run_miss(32'h0000_0A00, 1'b0, 32'h0);
    check_fill("restart", 32'h0000_0A00);
    chk("restart_counts", 64'({8'(n_line), 8'(n_done), 8'(n_err)}), 64'h01_01_00);

    // second miss_req while busy is ignored
    @(negedge clk);
    miss_addr = 32'h0000_1234; dirty = 1'b0; miss_req = 1'b1;
    start = cyc; wait_cnt = 0; clear_log();
    @(negedge clk);
    miss_req = 1'b0;
    repeat (3) @(negedge clk);
    miss_addr = 32'h0000_5000; miss_req = 1'b1;
    @(negedge clk);
    miss_req = 1'b0;
    wait_end();
    repeat (8) @(negedge clk);
    check_fill("ignored", 32'h0000_1220);
    chk("ignored_n_done", 64'(n_done), 64'd1);
    chk("ignored_idle", 64'(busy), 64'd0);
    run_miss(32'h0000_5000, 1'b0, 32'h0);
    check_fill("second", 32'h0000_5000);
    chk("second_n_done", 64'(n_done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
Miss-handling sequencer for one 8-word cache line.
- On a miss, it optionally writes back the dirty victim line to memory word-by-word.
- It then fetches the new line word-by-word over a req/ack memory interface and loads each word into CacheLineAdapter via its we/next/addr/data inputs.
- It waits for the adapter's full flag, pulses the cache line-write strobe, then clears the adapter.
- It sits between the cache tag/data array and the memory port.

Parameters:
WORDS, 8, words per cache line (power of two, ≥2)
ADDR_W, 32, address width
DATA_W, 32, data word width
TIMEOUT, 64, max cycles waiting for mem_ack or cla_full before error

Ports:
clk  in  1  clock, rising edge
clr  in  1  reset, asynchronous, active-low
miss_req  in  1  miss request; sampled only in IDLE
miss_addr  in  ADDR_W  missing byte address
dirty  in  1  victim line dirty; sampled with miss_req
victim_addr  in  ADDR_W  victim line byte address; sampled with miss_req
vic_idx  out  log2(WORDS)  victim word index presented to cache data array
vic_rdata  in  DATA_W  victim word at vic_idx (combinational from cache)
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  word byte address
mem_wdata  out  DATA_W  write data
mem_ack  in  1  one-cycle completion; rdata valid same cycle
mem_rdata  in  DATA_W  read data
cla_we  out  1  adapter write enable
cla_next  out  1  adapter advance strobe
cla_addr  out  ADDR_W  adapter word index (zero-extended)
cla_data  out  DATA_W  adapter write data
cla_full  in  1  adapter holds all WORDS words
cla_clr  out  1  adapter synchronous clear, active-high
line_we  out  1  one-cycle strobe: commit adapter line to cache
busy  out  1  controller not in IDLE
done  out  1  one-cycle strobe: miss serviced
err  out  1  one-cycle strobe: timeout abort

Behaviour:
- Reset (clr=0, async): state IDLE, word counter 0, timeout counter 0, latched addresses 0. All outputs are 0.
- Line alignment: low log2(WORDS*4) bits of miss_addr and victim_addr are cleared when latched. Word i address = base + 4*i.
- States and transitions:
  - IDLE: busy=0. On miss_req=1, latch both line bases and dirty, set i=0, then go to WB if dirty, else FILL. A miss_req outside IDLE is ignored.
  - WB: mem_req=1, mem_we=1, vic_idx=i, mem_addr=victim_base+4i, mem_wdata=vic_rdata. On mem_ack: i++, and after word WORDS-1 set i=0 and go to FILL.
  - FILL: mem_req=1, mem_we=0, mem_addr=miss_base+4i. In the mem_ack cycle, combinationally drive cla_we=1, cla_next=1, cla_addr=i, cla_data=mem_rdata. Then i++, and after word WORDS-1 go to WAIT_FULL.
  - WAIT_FULL: no memory request. When cla_full=1, go to COMMIT.
  - COMMIT: line_we=1 for exactly one cycle, then go to DONE.
  - DONE: done=1 and cla_clr=1 for one cycle, then go to IDLE.
  - ERR: err=1 and cla_clr=1 for one cycle, then go to IDLE. No line_we.
- Outside the cycles listed above, cla_we/cla_next/cla_data are 0.
- Timeout counter:
  - Cleared on state entry and on every mem_ack.
  - Increments each cycle in WB, FILL and WAIT_FULL.
  - Reaching TIMEOUT-1 without progress forces ERR next cycle.
  - A mem_ack in the same cycle as the limit wins (progress, no error).
- mem_ack while mem_req=0 is ignored. mem_addr/mem_we/mem_wdata stay stable while mem_req=1 and ack=0.
- Minimum latency miss_req→done (clean, ack every cycle, cla_full immediate) is WORDS+3 cycles. A dirty miss adds WORDS cycles.
- Reset mid-operation returns to IDLE immediately. No done or err is emitted, and partial adapter contents are the caller's to clear.

Test Plan:
- Clean miss, miss_addr=0x0000_1234, mem_ack every cycle, rdata=0xFFFF_FFFF-i → mem_addr 0x1220..0x123C reads; cla_addr 0..7 with matching data; line_we at cycle 10, done at 11.
- Dirty miss, victim_addr=0x8000_0040 → 8 writes to 0x8000_0040..0x5C with vic_idx 0..7 and mem_wdata=vic_rdata, then fill as above; done at cycle 19.
- Memory wait states (ack every 3rd cycle) → request and address held stable, exactly 8 cla_next pulses, full then line_we.
- No mem_ack for 64 cycles during FILL word 3 → err pulse with cla_clr, busy drops, no line_we or done.
- clr asserted low mid-FILL (word 5) → all outputs 0 asynchronously; a subsequent miss restarts at word 0.
- miss_req pulsed while busy → ignored; single done; the second miss is serviced only when re-asserted in IDLE.
